// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving a registered 4:1 mux with bounded hold time.
// Define ARB_PARK_EN to park the select on the last granted index while idle.
module mux4_rr_arbiter #(
  parameter int DW       = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    req,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  output logic [3:0]    gnt,
  output logic          s1,
  output logic          s0,
  output logic [DW-1:0] out,
  output logic          valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d, last_q, last_d, pick, park;
  logic [7:0]    hold_q, hold_d;
  logic [DW-1:0] out_q, out_d;
  logic          valid_q, valid_d, others, grant_new, go_idle;
`ifdef ARB_PARK_EN
  assign park = last_q;
`else
  assign park = 2'd0;
`endif
  assign others = |(req & ~(4'b0001 << last_q));
  always_comb begin
    pick = last_q;
    for (int k = 4; k >= 1; k--)
      if (req[last_q + 2'(k)]) pick = last_q + 2'(k);
  end
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hold_d    = hold_q;
    grant_new = 1'b0;
    go_idle   = 1'b0;
    if (state_q == IDLE) grant_new = |req;
    else if (!req[last_q]) begin
      grant_new = others;
      go_idle   = !others;
    end else if (hold_q == 8'(MAX_HOLD)) grant_new = others;
    else hold_d = hold_q + 8'd1;
    if (grant_new) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << pick;
      sel_d   = pick;
      last_d  = pick;
      hold_d  = 8'd1;
    end
    if (go_idle) begin
      state_d = IDLE;
      gnt_d   = 4'b0000;
      sel_d   = park;
      hold_d  = 8'd0;
    end
    out_d   = sel_q == 2'd0 ? i0 : sel_q == 2'd1 ? i1 : sel_q == 2'd2 ? i2 : i3;
    valid_d = |gnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      hold_q  <= 8'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end
  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign out   = out_q;
  assign valid = valid_q;
endmodule
